// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the 4:1 Wishbone arbiter.
// The round-robin pick is defined once here so the picker and any model agree.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TERM
  } wb_arb_state_e;

  localparam int WB_ARB_N_MASTERS = 4;
  localparam int WB_ARB_CNT_W     = 16;

  // One-hot grant for the first requester at or after last+1, wrapping mod 4.
  function automatic logic [WB_ARB_N_MASTERS-1:0] rr_pick(
    input logic [WB_ARB_N_MASTERS-1:0] req,
    input logic [1:0]                  last
  );
    logic [WB_ARB_N_MASTERS-1:0] g;
    logic [1:0]                  idx;
    logic                        found;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= WB_ARB_N_MASTERS; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone bundle with master/slave views.
interface wb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              CYC;
  logic              STB;
  logic              WE;
  logic [ADDR_W-1:0] ADR;
  logic [DATA_W-1:0] DAT_W;
  logic [DATA_W-1:0] DAT_R;
  logic [DATA_W/8-1:0] SEL;
  logic [2:0]        CTI;
  logic [1:0]        BTE;
  logic              ACK;
  logic              ERR;

  modport master (output CYC, STB, WE, ADR, DAT_W, SEL, CTI, BTE,
                  input  DAT_R, ACK, ERR);
  modport slave  (input  CYC, STB, WE, ADR, DAT_W, SEL, CTI, BTE,
                  output DAT_R, ACK, ERR);
endinterface

// File: rtl/wb_rr_arbiter.sv
// Combinational rotating-priority picker: requests plus last winner in,
// one-hot grant and any-request flag out.
module wb_rr_arbiter
  import wb_arb_pkg::*;
(
  input  logic [WB_ARB_N_MASTERS-1:0] req,
  input  logic [1:0]                  last,
  output logic [WB_ARB_N_MASTERS-1:0] gnt,
  output logic                        valid
);

  assign gnt   = rr_pick(req, last);
  assign valid = |req;

endmodule

// File: rtl/wb_arbiter_4x1.sv
// Four-master to one-slave Wishbone arbiter: round-robin grant held for a
// whole CYC, with a watchdog that errors out transfers the slave never answers.
module wb_arbiter_4x1
  import wb_arb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  wb_if.slave        m0,
  wb_if.slave        m1,
  wb_if.slave        m2,
  wb_if.slave        m3,
  wb_if.master       s0,
  output logic [3:0] gnt,
  output logic       timeout
);

  localparam int SEL_W = WB_DATA_WIDTH / 8;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [WB_ARB_CNT_W-1:0] CNT_LIMIT =
    WB_ARB_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [3:0]               req, stb, we, ack, err;
  logic [WB_ADDR_WIDTH-1:0] adr  [WB_ARB_N_MASTERS];
  logic [WB_DATA_WIDTH-1:0] datw [WB_ARB_N_MASTERS];
  logic [SEL_W-1:0]         sel  [WB_ARB_N_MASTERS];
  logic [2:0]               cti  [WB_ARB_N_MASTERS];
  logic [1:0]               bte  [WB_ARB_N_MASTERS];

  assign req = {m3.CYC, m2.CYC, m1.CYC, m0.CYC};
  assign stb = {m3.STB, m2.STB, m1.STB, m0.STB};
  assign we  = {m3.WE,  m2.WE,  m1.WE,  m0.WE};
  assign adr  = '{m0.ADR,   m1.ADR,   m2.ADR,   m3.ADR};
  assign datw = '{m0.DAT_W, m1.DAT_W, m2.DAT_W, m3.DAT_W};
  assign sel  = '{m0.SEL,   m1.SEL,   m2.SEL,   m3.SEL};
  assign cti  = '{m0.CTI,   m1.CTI,   m2.CTI,   m3.CTI};
  assign bte  = '{m0.BTE,   m1.BTE,   m2.BTE,   m3.BTE};

  wb_arb_state_e           state, state_n;
  logic [3:0]              gnt_n, pick;
  logic                    pick_vld;
  logic [1:0]              last, last_n;
  logic [WB_ARB_CNT_W-1:0] cnt, cnt_n;
  logic                    granted, resp, fire;

  wb_rr_arbiter u_rr (
    .req   (req),
    .last  (last),
    .gnt   (pick),
    .valid (pick_vld)
  );

  // While a grant is held, last equals the granted index, so it drives the mux.
  assign granted = (state == GRANT);
  assign resp    = s0.ACK | s0.ERR;
  assign fire    = WDOG_EN && granted && req[last] && stb[last] && !resp &&
                   (cnt == CNT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    cnt_n   = '0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_n = GRANT;
          gnt_n   = pick;
          for (int i = 0; i < WB_ARB_N_MASTERS; i++) begin
            if (pick[i]) last_n = 2'(i);
          end
        end
      end
      GRANT: begin
        if (resp)           cnt_n = '0;
        else if (stb[last]) cnt_n = cnt + 1'b1;
        else                cnt_n = cnt;
        if (fire) begin
          state_n = TERM;
        end else if (!req[last]) begin
          state_n = IDLE;
          gnt_n   = '0;
        end
      end
      TERM: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  assign timeout  = (state == TERM);
  assign s0.CYC   = granted & req[last];
  assign s0.STB   = granted & stb[last];
  assign s0.WE    = granted & we[last];
  assign s0.ADR   = adr[last];
  assign s0.DAT_W = datw[last];
  assign s0.SEL   = sel[last];
  assign s0.CTI   = cti[last];
  assign s0.BTE   = bte[last];

  always_comb begin
    ack = '0;
    err = '0;
    if (granted) begin
      ack[last] = s0.ACK;
      err[last] = s0.ERR;
    end else if (state == TERM) begin
      err[last] = 1'b1;
    end
  end

  assign m0.ACK = ack[0];
  assign m1.ACK = ack[1];
  assign m2.ACK = ack[2];
  assign m3.ACK = ack[3];
  assign m0.ERR = err[0];
  assign m1.ERR = err[1];
  assign m2.ERR = err[2];
  assign m3.ERR = err[3];
  assign m0.DAT_R = s0.DAT_R;
  assign m1.DAT_R = s0.DAT_R;
  assign m2.DAT_R = s0.DAT_R;
  assign m3.DAT_R = s0.DAT_R;

endmodule
